// File: rtl/memory_access.sv
// memory_access: MEM stage of the DHRUT-V core.
// Drives loads/stores onto a request/ready/rvalid data-memory bus, formats load
// data and registers the writeback/forwarding bundle. o_stall holds IF/ID/EX
// while a bus transaction is in flight.
// Optional feature: define MEM_MISALIGN_TRAP_EN to detect misaligned half/word
// accesses, suppress their bus request and pulse o_misaligned.
module memory_access #(
  parameter int DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        i_result,
  input  logic [31:0]        i_data_store,
  input  logic [31:0]        i_pc,
  input  logic [2:0]         i_func3,
  input  logic [6:0]         i_opcode,
  input  logic [4:0]         i_rd,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [DMEM_AW-1:0] o_dmem_addr,
  output logic [31:0]        o_dmem_wdata,
  output logic [3:0]         o_dmem_wstrb,
  input  logic               i_dmem_ready,
  input  logic               i_dmem_rvalid,
  input  logic [31:0]        i_dmem_rdata,
  output logic [31:0]        o_wb_data,
  output logic [4:0]         o_rd,
  output logic               o_wb_en,
  output logic [31:0]        o_pc,
  output logic [6:0]         o_opcode,
  output logic               o_stall,
  output logic               o_misaligned
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state;
  logic [31:0] load_data;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misaligned_access;
  logic [1:0]  lo;
  logic [31:0] store_wdata;
  logic [3:0]  store_wstrb;
  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [31:0] load_fmt;

  assign lo       = i_result[1:0];
  assign is_load  = (i_opcode == OP_LOAD);
  assign is_store = (i_opcode == OP_STORE);
  assign is_mem   = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_q;

  // Flag halfword accesses on odd bytes and word accesses off a word boundary
  always_comb begin
    misaligned_access = 1'b0;
    case (i_func3)
      3'b000, 3'b100: misaligned_access = 1'b0;
      3'b001, 3'b101: misaligned_access = is_mem & lo[0];
      default:        misaligned_access = is_mem & (lo != 2'b00);
    endcase
  end

  assign o_misaligned = misaligned_q;
`else
  assign misaligned_access = 1'b0;
  assign o_misaligned      = 1'b0;
`endif

  // Replicate store data across lanes and build the byte-enable mask
  always_comb begin
    store_wdata = i_data_store;
    store_wstrb = 4'b1111;
    case (i_func3)
      3'b000: begin
        store_wdata = {4{i_data_store[7:0]}};
        store_wstrb = 4'b0001 << lo;
      end
      3'b001: begin
        store_wdata = {2{i_data_store[15:0]}};
        store_wstrb = 4'b0011 << {lo[1], 1'b0};
      end
      default: begin
        store_wdata = i_data_store;
        store_wstrb = 4'b1111;
      end
    endcase
  end

  // Select the addressed lane of the read word and sign/zero extend it
  always_comb begin
    byte_shift = i_dmem_rdata >> {lo, 3'b000};
    half_shift = i_dmem_rdata >> {lo[1], 4'b0000};
    load_fmt   = i_dmem_rdata;
    case (i_func3)
      3'b000:  load_fmt = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b001:  load_fmt = {{16{half_shift[15]}}, half_shift[15:0]};
      3'b100:  load_fmt = {24'h000000, byte_shift[7:0]};
      3'b101:  load_fmt = {16'h0000, half_shift[15:0]};
      default: load_fmt = i_dmem_rdata;
    endcase
  end

  assign o_stall = ((state == IDLE) && is_mem) || (state == REQ) || (state == RESP);

  // Transaction FSM with registered bus and writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      load_data    <= '0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_wstrb <= '0;
      o_wb_data    <= '0;
      o_rd         <= '0;
      o_wb_en      <= 1'b0;
      o_pc         <= '0;
      o_opcode     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (is_mem) begin
            o_wb_en      <= 1'b0;
            o_dmem_addr  <= {i_result[DMEM_AW-1:2], 2'b00};
            o_dmem_we    <= is_store;
            o_dmem_wdata <= is_store ? store_wdata : 32'h0;
            o_dmem_wstrb <= is_store ? store_wstrb : 4'b0000;
            if (misaligned_access) begin
              state <= DONE;
            end else begin
              o_dmem_req <= 1'b1;
              state      <= REQ;
            end
          end else begin
            o_wb_data <= i_result;
            o_rd      <= i_rd;
            o_pc      <= i_pc;
            o_opcode  <= i_opcode;
            o_wb_en   <= (i_opcode != OP_BRANCH) && (i_rd != 5'd0);
          end
        end
        REQ: begin
          if (i_dmem_ready) begin
            o_dmem_req <= 1'b0;
            state      <= o_dmem_we ? DONE : RESP;
          end
        end
        RESP: begin
          if (i_dmem_rvalid) begin
            load_data <= load_fmt;
            state     <= DONE;
          end
        end
        DONE: begin
          o_wb_data <= is_store ? i_result : load_data;
          o_rd      <= i_rd;
          o_pc      <= i_pc;
          o_opcode  <= i_opcode;
          o_wb_en   <= is_load && !misaligned_access && (i_rd != 5'd0);
`ifdef MEM_MISALIGN_TRAP_EN
          misaligned_q <= misaligned_access;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: randomized self-checking bench for memory_access.
// A behavioural byte-lane model predicts bus fields, stall length and
// writeback values; a small memory responder drives ready/rvalid.
module tb_memory_access;

  localparam int AW = 32;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic          clk;
  logic          rst;
  logic [31:0]   i_result;
  logic [31:0]   i_data_store;
  logic [31:0]   i_pc;
  logic [2:0]    i_func3;
  logic [6:0]    i_opcode;
  logic [4:0]    i_rd;
  logic          o_dmem_req;
  logic          o_dmem_we;
  logic [AW-1:0] o_dmem_addr;
  logic [31:0]   o_dmem_wdata;
  logic [3:0]    o_dmem_wstrb;
  logic          i_dmem_ready;
  logic          i_dmem_rvalid;
  logic [31:0]   i_dmem_rdata;
  logic [31:0]   o_wb_data;
  logic [4:0]    o_rd;
  logic          o_wb_en;
  logic [31:0]   o_pc;
  logic [6:0]    o_opcode;
  logic          o_stall;
  logic          o_misaligned;

  int chk_cnt = 0;
  int err_cnt = 0;

  memory_access #(.DMEM_AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_result     (i_result),
    .i_data_store (i_data_store),
    .i_pc         (i_pc),
    .i_func3      (i_func3),
    .i_opcode     (i_opcode),
    .i_rd         (i_rd),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_wdata (o_dmem_wdata),
    .o_dmem_wstrb (o_dmem_wstrb),
    .i_dmem_ready (i_dmem_ready),
    .i_dmem_rvalid(i_dmem_rvalid),
    .i_dmem_rdata (i_dmem_rdata),
    .o_wb_data    (o_wb_data),
    .o_rd         (o_rd),
    .o_wb_en      (o_wb_en),
    .o_pc         (o_pc),
    .o_opcode     (o_opcode),
    .o_stall      (o_stall),
    .o_misaligned (o_misaligned)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Access size in bytes for a func3 value; unused encodings act as words
  function automatic int modelSize(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit modelMisaligned(input logic [2:0] f3, input logic [1:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    int sz = modelSize(f3);
    return (int'(a) % sz) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Lane i carries store byte (i mod size); enabled lanes are the size-block holding a
  task automatic modelStore(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d,
                            output logic [31:0] wd, output logic [3:0] ws);
    int sz = modelSize(f3);
    logic [7:0] bytes [4];
    for (int i = 0; i < 4; i++) bytes[i] = d[8*i +: 8];
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = bytes[i % sz];
      ws[i]        = (i / sz) == (int'(a) / sz);
    end
  endtask

  // Assemble the addressed lane as an integer and extend it arithmetically
  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    int sz = modelSize(f3);
    int start = (int'(a) / sz) * sz;
    longint val = 0;
    for (int k = sz - 1; k >= 0; k--) val = val * 256 + longint'(w[8*(start+k) +: 8]);
    if ((f3 == 3'd0 || f3 == 3'd1) && val >= (longint'(1) << (8*sz - 1)))
      val = val - (longint'(1) << (8*sz));
    return val[31:0];
  endfunction

  // Present one instruction, act as the memory, then check bus, stall and writeback
  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] res,
                               input logic [31:0] sdata, input logic [4:0] rd,
                               input int ready_wait, input int rvalid_delay, input logic [31:0] rdata);
    bit is_load, is_store, is_mem, mis, done, accepted, bus_bad;
    int stall_cnt, req_cnt, since_acc, exp_stall;
    logic [31:0] exp_wdata, exp_wb, pc;
    logic [3:0] exp_wstrb;
    pc           = $urandom;
    i_opcode     = opc;
    i_func3      = f3;
    i_result     = res;
    i_data_store = sdata;
    i_rd         = rd;
    i_pc         = pc;
    is_load  = (opc == OP_L);
    is_store = (opc == OP_S);
    is_mem   = is_load || is_store;
    mis      = is_mem && modelMisaligned(f3, res[1:0]);
    modelStore(f3, res[1:0], sdata, exp_wdata, exp_wstrb);
    stall_cnt = 0; req_cnt = 0; since_acc = 0;
    accepted = 0; done = 0; bus_bad = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (o_stall) stall_cnt++;
      if (accepted) since_acc++;
      i_dmem_rvalid = accepted ? (since_acc == rvalid_delay) : 1'($urandom_range(0, 1));
      i_dmem_rdata  = (accepted && since_acc == rvalid_delay) ? rdata : $urandom;
      i_dmem_ready  = 1'($urandom_range(0, 1));
      if (o_dmem_req) begin
        req_cnt++;
        if (o_dmem_addr !== {res[31:2], 2'b00} || o_dmem_we !== is_store) bus_bad = 1;
        if (is_store && (o_dmem_wdata !== exp_wdata || o_dmem_wstrb !== exp_wstrb)) bus_bad = 1;
        i_dmem_ready = (req_cnt > ready_wait);
        if (req_cnt > ready_wait) accepted = 1;
      end
      if (!o_stall) done = 1;
      @(posedge clk);
      #1;
    end
    i_dmem_ready  = 1'b0;
    i_dmem_rvalid = 1'b0;
    if (!is_mem)       exp_stall = 0;
    else if (mis)      exp_stall = 1;
    else if (is_store) exp_stall = ready_wait + 2;
    else               exp_stall = ready_wait + 2 + rvalid_delay;
    checkOutput("completed", 32'(done), 32'd1);
    checkOutput("stall_cycles", stall_cnt, exp_stall);
    if (is_mem) begin
      checkOutput("req_cycles", req_cnt, mis ? 0 : ready_wait + 1);
      checkOutput("bus_fields", 32'(bus_bad), 32'd0);
    end
    if (is_store)    checkOutput("wb_en", 32'(o_wb_en), 32'd0);
    else if (is_load) checkOutput("wb_en", 32'(o_wb_en), 32'(!mis && rd != 0));
    else             checkOutput("wb_en", 32'(o_wb_en), 32'(opc != OP_B && rd != 0));
    if (!is_store && !mis) begin
      exp_wb = is_load ? modelLoad(f3, res[1:0], rdata) : res;
      checkOutput("wb_data", o_wb_data, exp_wb);
    end
    checkOutput("rd", 32'(o_rd), 32'(rd));
    checkOutput("pc", o_pc, pc);
    checkOutput("opcode", 32'(o_opcode), 32'(opc));
    checkOutput("misaligned", 32'(o_misaligned), 32'(mis));
  endtask

  // Main sequence: reset, directed cases, reset during RESP, random traffic
  initial begin
    rst = 1'b1;
    i_result = '0; i_data_store = '0; i_pc = '0; i_func3 = '0;
    i_opcode = '0; i_rd = '0; i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", 32'(o_dmem_req), 32'd0);
    checkOutput("rst_we", 32'(o_dmem_we), 32'd0);
    checkOutput("rst_addr", o_dmem_addr, 32'd0);
    checkOutput("rst_wdata", o_dmem_wdata, 32'd0);
    checkOutput("rst_wstrb", 32'(o_dmem_wstrb), 32'd0);
    checkOutput("rst_wb_data", o_wb_data, 32'd0);
    checkOutput("rst_rd", 32'(o_rd), 32'd0);
    checkOutput("rst_wb_en", 32'(o_wb_en), 32'd0);
    checkOutput("rst_pc", o_pc, 32'd0);
    checkOutput("rst_opcode", 32'(o_opcode), 32'd0);
    checkOutput("rst_misaligned", 32'(o_misaligned), 32'd0);
    checkOutput("rst_stall", 32'(o_stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(OP_R, 3'd0, 32'd5, 32'd0, 5'd3, 0, 1, 32'd0);
    applyStimulus(OP_R, 3'd0, 32'd5, 32'd0, 5'd0, 0, 1, 32'd0);
    applyStimulus(OP_S, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 0, 1, 32'd0);
    applyStimulus(OP_S, 3'd1, 32'h202, 32'h1234ABCD, 5'd0, 0, 1, 32'd0);
    applyStimulus(OP_L, 3'd0, 32'h103, 32'd0, 5'd9, 0, 1, 32'h80000000);
    applyStimulus(OP_L, 3'd4, 32'h103, 32'd0, 5'd9, 0, 1, 32'h80000000);
    applyStimulus(OP_L, 3'd2, 32'h200, 32'd0, 5'd4, 2, 2, 32'hCAFEF00D);
    applyStimulus(OP_L, 3'd2, 32'h101, 32'd0, 5'd6, 0, 1, 32'h11223344);

    $display("[TB] reset while waiting for read data");
    i_opcode = OP_L; i_func3 = 3'd2; i_result = 32'h300; i_rd = 5'd8; i_pc = 32'h40;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rr_req", 32'(o_dmem_req), 32'd1);
    i_dmem_ready = 1'b1;
    @(posedge clk);
    #1;
    i_dmem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rr_stall_resp", 32'(o_stall), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_opcode = OP_I; i_result = 32'h55; i_rd = 5'd7; i_pc = 32'h44;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hFFFF0000;
    checkOutput("rr_req_dropped", 32'(o_dmem_req), 32'd0);
    checkOutput("rr_wb_cleared", o_wb_data, 32'd0);
    @(negedge clk);
    checkOutput("rr_stall_idle", 32'(o_stall), 32'd0);
    @(posedge clk);
    #1;
    i_dmem_rvalid = 1'b0;
    checkOutput("rr_wb_data", o_wb_data, 32'h55);
    checkOutput("rr_wb_en", 32'(o_wb_en), 32'd1);
    checkOutput("rr_req_idle", 32'(o_dmem_req), 32'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      int sel;
      logic [2:0] f3;
      logic [6:0] opc;
      sel = $urandom_range(0, 4);
      case (sel)
        0: begin opc = OP_R; f3 = 3'($urandom_range(0, 7)); end
        1: begin opc = OP_I; f3 = 3'($urandom_range(0, 7)); end
        2: begin opc = OP_B; f3 = 3'($urandom_range(0, 7)); end
        3: begin
          opc = OP_L;
          case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
        end
        default: begin opc = OP_S; f3 = 3'($urandom_range(0, 2)); end
      endcase
      applyStimulus(opc, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 2), $urandom_range(1, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
